neuron_weight_stream: RTL and testbench
=======================================

Name: neuron_weight_stream

Overview:
- Parametrised successor to the fixed per-neuron weight ROMs.
- Writable weight store: host loads weights through a write port; a burst sequencer then streams a contiguous run of weights to the MAC datapath over a valid/ready handshake.
- Sits between the weight-load bus and one perceptron MAC lane; one instance per neuron.

Parameters:
- DATA_W, 16, weight word width in bits.
- DEPTH, 1024, number of weight words; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), address width (derived, do not override).
- CNT_W, ADDR_W+1, burst length width so that count = DEPTH is representable.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the weight store.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- start  in  1  one-cycle burst request; sampled only when busy=0.
- base_addr  in  ADDR_W  first address of the burst; sampled with start.
- count  in  CNT_W  number of words in the burst; sampled with start.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  out  1  one-cycle pulse after the last beat is accepted.
- w_valid  out  1  w_data/w_index are valid.
- w_ready  in  1  consumer accepts the beat when w_valid and w_ready are both high.
- w_data  out  DATA_W  weight word.
- w_index  out  CNT_W  beat number within the burst, 0..count-1.
- par_err  out  1  present only with NEURON_PARITY_EN (see Optional Feature).

Behaviour:
- Reset values: busy=0, done=0, w_valid=0, w_data=0, w_index=0, par_err=0. FSM goes to IDLE and all counters clear. Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. No done pulse is issued.
- FSM states:
  - IDLE: start=1 with count>0 → RUN. start=1 with count=0 → DONE.
  - RUN: when the last beat handshakes → DONE.
  - DONE: asserts done for one cycle → IDLE.
- start while busy=1 is ignored.
- Read engine:
  - Memory read has 1-cycle registered latency.
  - Output is a 2-entry skid buffer.
  - A read is issued when reads remain and (occupancy + reads_in_flight − pop_this_cycle) < 2.
- Latency: start accepted at cycle 0 → first read issued at cycle 1 → w_valid=1 at cycle 2.
- Throughput: with w_ready held high, one beat per cycle; the last beat appears at cycle count+1.
- Backpressure: while w_valid=1 and w_ready=0, w_data/w_index hold stable. No beat is lost or duplicated.
- Addressing: read address = (base_addr + issued) mod DEPTH; it wraps from DEPTH−1 to 0.
- count > DEPTH is clamped to DEPTH.
- Write/read collision on the same address in the same cycle returns the old data (read-before-write). Later reads see the new data.
- Writes are accepted in every state, including during a burst.
- done asserts in the cycle after the final handshake; busy deasserts in that same cycle.

Optional Feature:
- Macro: NEURON_PARITY_EN.
- Defined:
  - Each stored word carries one extra even-parity bit, computed on write.
  - On read, parity is checked as the word enters the skid buffer.
  - A mismatch sets par_err, which is sticky until rst or the next accepted start.
  - Data is still delivered.
- Undefined:
  - No parity storage, no par_err port.
  - Memory is DATA_W wide.

Decomposition:
- Package neuron_pkg:
  - FSM state enum (IDLE, RUN, DONE).
  - Default DATA_W/DEPTH localparams.
  - Parity helper function.
- Sub-module neuron_weight_ram:
  - Simple dual-port RAM, one write port, one registered read port, read-before-write.
  - Width = DATA_W (+1 with NEURON_PARITY_EN).

Test Plan:
- Load addr 0..9 with 16'h0100*i; start base=3 count=4, w_ready=1 → w_valid first at cycle 2, data 0300,0400,0500,0600, w_index 0..3; done pulse 1 cycle after the last beat.
- Same burst with w_ready toggling 1,0,0,1,… → identical data sequence, outputs stable while stalled, no duplicates.
- DEPTH=16, base=14 count=4 → addresses 14,15,0,1 delivered in order.
- count=0 → no w_valid, done=1 at cycle 1, busy never asserts; start during busy → ignored, burst unchanged.
- Write addr 5=16'hBEEF in the same cycle the read of addr 5 is issued → old value delivered; next burst returns BEEF.
- rst pulsed mid-burst → all outputs 0 asynchronously, no done; with NEURON_PARITY_EN, a forced bit flip in RAM → par_err=1 and sticky until the next start.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared FSM state type, default sizing and the parity helper
// used by the neuron weight-stream slice (neuron_weight_ram, neuron_weight_stream).
package neuron_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_DEPTH  = 1024;
    localparam int PARITY_MAX_W   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } neuronState_t;

    // Even parity over a word zero-extended to PARITY_MAX_W bits; the returned
    // bit makes the total number of ones (word plus parity) even.
    function automatic logic evenParity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/neuron_weight_ram.sv
// neuron_weight_ram: simple dual-port weight store with one write port and one
// registered read port. A read and a write to the same address in the same
// cycle return the old contents (read-before-write).
module neuron_weight_ram
    import neuron_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    // Memory array and read register share one clocked process so the read
    // samples the array before the same-edge write lands; no reset on storage.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rdData <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rdData;

endmodule

// File: rtl/neuron_weight_stream.sv
// neuron_weight_stream: writable per-neuron weight store plus a burst
// sequencer that streams a contiguous, wrapping run of weights to one MAC lane
// over valid/ready. The RAM read register acts as the in-flight stage and a
// 2-entry skid buffer absorbs backpressure.
// Optional build macro: NEURON_PARITY_EN adds a stored even-parity bit per
// word and the sticky o_par_err output.
module neuron_weight_stream
    import neuron_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    output logic [DATA_W-1:0] o_w_data,
    output logic [CNT_W-1:0]  o_w_index
`ifdef NEURON_PARITY_EN
   ,output logic              o_par_err
`endif
);

`ifdef NEURON_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    neuronState_t      r_state;
    neuronState_t      w_nextState;

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_outIdx;
    logic              r_inFlight;

    logic [MEM_W-1:0]  r_skid [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_occ;

    logic              w_startAccept;
    logic [CNT_W-1:0]  w_countClamped;
    logic              w_readsRemain;
    logic              w_valid;
    logic              w_pop;
    logic              w_popBuf;
    logic              w_push;
    logic [2:0]        w_pending;
    logic [2:0]        w_level;
    logic              w_issue;
    logic              w_lastBeat;
    logic [ADDR_W-1:0] w_rdAddr;
    logic [MEM_W-1:0]  w_wrWord;
    logic [MEM_W-1:0]  w_rdData;
    logic [MEM_W-1:0]  w_outWord;

    assign w_startAccept  = (r_state == IDLE) && i_start;
    assign w_countClamped = (i_count > DEPTH_CNT) ? DEPTH_CNT : i_count;

    assign w_valid   = (r_occ != 2'd0) || r_inFlight;
    assign w_pop     = w_valid && i_w_ready;
    assign w_popBuf  = w_pop && (r_occ != 2'd0);
    assign w_push    = r_inFlight && !((r_occ == 2'd0) && w_pop);
    assign w_outWord = (r_occ != 2'd0) ? r_skid[r_head] : w_rdData;

    assign w_readsRemain = (r_state == RUN) && (r_issued != r_count);
    assign w_pending     = {1'b0, r_occ} + {2'b00, r_inFlight};
    assign w_level       = w_pending - {2'b00, w_pop};
    assign w_issue       = w_readsRemain && (w_level < 3'd2);
    assign w_lastBeat    = (r_state == RUN) && w_pop && (r_outIdx == (r_count - CNT_ONE));

    assign w_rdAddr = r_base + r_issued[ADDR_W-1:0];

`ifdef NEURON_PARITY_EN
    assign w_wrWord = {evenParity(PARITY_MAX_W'(i_wr_data)), i_wr_data};
`else
    assign w_wrWord = i_wr_data;
`endif

    neuron_weight_ram #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (w_wrWord),
        .i_rd_en   (w_issue),
        .i_rd_addr (w_rdAddr),
        .o_rd_data (w_rdData)
    );

    // FSM state register; reset drops any burst straight back to IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a zero-length burst skips RUN, RUN ends on the last handshake.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = (w_countClamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: capture base/count on start, then count issued reads and delivered beats.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base   <= '0;
            r_count  <= '0;
            r_issued <= '0;
            r_outIdx <= '0;
        end else if (w_startAccept) begin
            r_base   <= i_base_addr;
            r_count  <= w_countClamped;
            r_issued <= '0;
            r_outIdx <= '0;
        end else begin
            if (w_issue) begin
                r_issued <= r_issued + CNT_ONE;
            end
            if (w_pop) begin
                r_outIdx <= r_outIdx + CNT_ONE;
            end
        end
    end

    // Tracks whether the RAM read register holds a word issued last cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inFlight <= 1'b0;
        end else begin
            r_inFlight <= w_issue;
        end
    end

    // Skid buffer: an arriving word that is not consumed straight from the RAM is parked here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_skid[0] <= '0;
            r_skid[1] <= '0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            if (w_push) begin
                r_skid[r_tail] <= w_rdData;
                r_tail         <= ~r_tail;
            end
            if (w_popBuf) begin
                r_head <= ~r_head;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_popBuf};
        end
    end

`ifdef NEURON_PARITY_EN
    logic r_parErr;
    logic w_parMismatch;

    assign w_parMismatch = r_inFlight &&
                           (w_rdData[DATA_W] != evenParity(PARITY_MAX_W'(w_rdData[DATA_W-1:0])));

    // Sticky parity flag: cleared by a new accepted burst, set by any bad word entering the buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_parErr <= 1'b0;
        end else if (w_startAccept) begin
            r_parErr <= 1'b0;
        end else if (w_parMismatch) begin
            r_parErr <= 1'b1;
        end
    end

    assign o_par_err = r_parErr;
`endif

    assign o_busy    = (r_state == RUN);
    assign o_done    = (r_state == DONE);
    assign o_w_valid = w_valid;
    assign o_w_data  = w_valid ? w_outWord[DATA_W-1:0] : '0;
    assign o_w_index = w_valid ? r_outIdx : '0;

endmodule

// File: tb/tb_neuron_weight_stream.sv
// tb_neuron_weight_stream: directed, self-checking bench for neuron_weight_stream
// built with DEPTH=16 so address wrap and count clamping are easy to reach.
// Parity checks are compiled in when NEURON_PARITY_EN is defined.
module tb_neuron_weight_stream;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              start;
    logic [ADDR_W-1:0] baseAddr;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic              wValid;
    logic              wReady;
    logic [DATA_W-1:0] wData;
    logic [CNT_W-1:0]  wIndex;
`ifdef NEURON_PARITY_EN
    logic              parErr;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] wrapExp [4];

    neuron_weight_stream #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wrEn),
        .i_wr_addr   (wrAddr),
        .i_wr_data   (wrData),
        .i_start     (start),
        .i_base_addr (baseAddr),
        .i_count     (count),
        .o_busy      (busy),
        .o_done      (done),
        .o_w_valid   (wValid),
        .i_w_ready   (wReady),
        .o_w_data    (wData),
        .o_w_index   (wIndex)
`ifdef NEURON_PARITY_EN
       ,.o_par_err   (parErr)
`endif
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run with a report.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 2 time units after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input logic expValid, input logic [15:0] expData, input int expIdx);
        checkOutput({tag, "_valid"}, 32'(wValid), 32'(expValid));
        checkOutput({tag, "_data"}, 32'(wData), 32'(expData));
        checkOutput({tag, "_index"}, 32'(wIndex), 32'(expIdx));
    endtask

    task automatic checkControl(input string tag, input logic expBusy, input logic expDone);
        checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
    endtask

    // Present a one-cycle start; returns in cycle 1 of the burst.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        start    = 1'b1;
        baseAddr = base;
        count    = cnt;
        nextCycle();
        start    = 1'b0;
    endtask

    task automatic writeWord(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wrEn   = 1'b1;
        wrAddr = addr;
        wrData = data;
        nextCycle();
        wrEn   = 1'b0;
    endtask

    // Directed sequence: reset, load, then one block per scenario.
    initial begin
        int k;
        int doneCnt;

        rst      = 1'b1;
        wrEn     = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        start    = 1'b0;
        baseAddr = '0;
        count    = '0;
        wReady   = 1'b1;
        wrapExp  = '{16'h0E00, 16'h0F00, 16'h0000, 16'h0100};

        nextCycle();
        nextCycle();
        checkControl("reset", 1'b0, 1'b0);
        checkBeat("reset", 1'b0, 16'h0000, 0);
`ifdef NEURON_PARITY_EN
        checkOutput("reset_par_err", 32'(parErr), 32'd0);
`endif
        rst = 1'b0;
        nextCycle();

        $display("[TB] loading weights");
        for (int i = 0; i < DEPTH; i++) begin
            writeWord(ADDR_W'(i), 16'(16'h0100 * i));
        end

        $display("[TB] burst base=3 count=4 ready=1");
        applyStimulus(4'd3, 5'd4);
        checkControl("b1_c1", 1'b1, 1'b0);
        checkBeat("b1_c1", 1'b0, 16'h0000, 0);
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            checkBeat("b1_beat", 1'b1, 16'(16'h0100 * (3 + b)), b);
            checkControl("b1_beat", 1'b1, 1'b0);
        end
        nextCycle();
        checkControl("b1_end", 1'b0, 1'b1);
        checkOutput("b1_end_valid", 32'(wValid), 32'd0);
        nextCycle();
        checkControl("b1_after", 1'b0, 1'b0);

        $display("[TB] burst base=3 count=4 with backpressure");
        applyStimulus(4'd3, 5'd4);
        k       = 0;
        doneCnt = 0;
        for (int c = 1; c <= 20; c++) begin
            wReady = ((c % 3) == 1);
            if (wValid) begin
                checkOutput("bp_data", 32'(wData), 32'(16'(16'h0100 * (3 + k))));
                checkOutput("bp_index", 32'(wIndex), 32'(k));
                if (wReady) begin
                    k++;
                end
            end
            if (done) begin
                doneCnt++;
            end
            nextCycle();
        end
        wReady = 1'b1;
        checkOutput("bp_beats", 32'(k), 32'd4);
        checkOutput("bp_done_pulses", 32'(doneCnt), 32'd1);

        $display("[TB] wrapping burst base=14 count=4");
        applyStimulus(4'd14, 5'd4);
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            checkBeat("wrap_beat", 1'b1, wrapExp[b], b);
        end
        nextCycle();
        checkControl("wrap_end", 1'b0, 1'b1);

        $display("[TB] clamped burst count=20");
        nextCycle();
        applyStimulus(4'd0, 5'd20);
        for (int b = 0; b < DEPTH; b++) begin
            nextCycle();
            checkBeat("clamp_beat", 1'b1, 16'(16'h0100 * b), b);
        end
        nextCycle();
        checkControl("clamp_end", 1'b0, 1'b1);
        checkOutput("clamp_end_valid", 32'(wValid), 32'd0);

        $display("[TB] zero-length burst");
        nextCycle();
        checkControl("zero_c0", 1'b0, 1'b0);
        applyStimulus(4'd7, 5'd0);
        checkControl("zero_c1", 1'b0, 1'b1);
        checkOutput("zero_c1_valid", 32'(wValid), 32'd0);
        nextCycle();
        checkControl("zero_c2", 1'b0, 1'b0);
        checkOutput("zero_c2_valid", 32'(wValid), 32'd0);

        $display("[TB] start while busy is ignored");
        applyStimulus(4'd0, 5'd3);
        nextCycle();
        checkBeat("busy_b0", 1'b1, 16'h0000, 0);
        start    = 1'b1;
        baseAddr = 4'd8;
        count    = 5'd2;
        nextCycle();
        start    = 1'b0;
        checkBeat("busy_b1", 1'b1, 16'h0100, 1);
        nextCycle();
        checkBeat("busy_b2", 1'b1, 16'h0200, 2);
        nextCycle();
        checkControl("busy_end", 1'b0, 1'b1);
        nextCycle();
        checkControl("busy_idle", 1'b0, 1'b0);
        checkOutput("busy_idle_valid", 32'(wValid), 32'd0);
        nextCycle();
        checkOutput("busy_idle2_valid", 32'(wValid), 32'd0);

        $display("[TB] read/write collision on addr 5");
        applyStimulus(4'd5, 5'd1);
        wrEn   = 1'b1;
        wrAddr = 4'd5;
        wrData = 16'hBEEF;
        nextCycle();
        wrEn   = 1'b0;
        checkBeat("coll_old", 1'b1, 16'h0500, 0);
        nextCycle();
        checkControl("coll_end", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'd5, 5'd1);
        nextCycle();
        checkBeat("coll_new", 1'b1, 16'hBEEF, 0);
        nextCycle();
        nextCycle();

        $display("[TB] reset mid-burst");
        applyStimulus(4'd0, 5'd8);
        nextCycle();
        nextCycle();
        checkBeat("rst_pre", 1'b1, 16'h0100, 1);
        #1;
        rst = 1'b1;
        #1;
        checkControl("rst_async", 1'b0, 1'b0);
        checkBeat("rst_async", 1'b0, 16'h0000, 0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            checkControl("rst_after", 1'b0, 1'b0);
            checkOutput("rst_after_valid", 32'(wValid), 32'd0);
        end
        applyStimulus(4'd2, 5'd1);
        nextCycle();
        checkBeat("rst_recover", 1'b1, 16'h0200, 0);
        nextCycle();
        checkControl("rst_recover_end", 1'b0, 1'b1);
        nextCycle();

`ifdef NEURON_PARITY_EN
        $display("[TB] parity error on flipped RAM bit");
        u_dut.u_ram.r_mem[9][3] = ~u_dut.u_ram.r_mem[9][3];
        applyStimulus(4'd9, 5'd1);
        checkOutput("par_c1", 32'(parErr), 32'd0);
        nextCycle();
        checkBeat("par_data", 1'b1, 16'h0908, 0);
        nextCycle();
        checkOutput("par_set", 32'(parErr), 32'd1);
        nextCycle();
        nextCycle();
        checkOutput("par_sticky", 32'(parErr), 32'd1);
        applyStimulus(4'd2, 5'd1);
        checkOutput("par_clear", 32'(parErr), 32'd0);
        nextCycle();
        nextCycle();
        checkOutput("par_clean", 32'(parErr), 32'd0);
        nextCycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
